// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_tx
//  Description : Pops 16-bit words from the TX FIFO and serializes each one as
//                two UART bytes (8 data bits, optional parity, 1 or 2 stops).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx #(
   parameter bit          LSB_FIRST_BYTE = 1'b1,
   parameter bit          PARITY_EN      = 1'b0,
   parameter bit          PARITY_ODD     = 1'b0,
   parameter int unsigned STOP_BITS      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] baud_divisor,
   input  logic [15:0] fifo_data,
   input  logic        fifo_empty,
   output logic        rd_en,
   output logic        tx,
   output logic        busy,
   output logic        word_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_LATCH  = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   localparam logic [2:0] c_last_data = 3'd7;
   localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);

   state_t      r_state;
   logic [15:0] r_word;
   logic [15:0] r_div;
   logic [15:0] r_baud_cnt;
   logic [2:0]  r_bit_cnt;
   logic        r_byte_idx;
   logic        r_word_done;
   logic        r_tx;

   state_t      w_state_nxt;
   logic [15:0] w_word_nxt;
   logic [15:0] w_div_nxt;
   logic [15:0] w_baud_cnt_nxt;
   logic [2:0]  w_bit_cnt_nxt;
   logic        w_byte_idx_nxt;
   logic        w_word_done_nxt;
   logic        w_tx_nxt;
   logic        w_bit_end;
   logic [7:0]  w_byte_nxt;

   always_comb begin
      w_state_nxt     = r_state;
      w_word_nxt      = r_word;
      w_div_nxt       = r_div;
      w_baud_cnt_nxt  = r_baud_cnt;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_byte_idx_nxt  = r_byte_idx;
      w_word_done_nxt = 1'b0;
      w_bit_end       = (r_baud_cnt == (r_div - 16'd1));

      case (r_state)
         S_IDLE: begin
            if (enable && !fifo_empty) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_state_nxt = S_LATCH;
         end
         S_LATCH: begin
            // Divisor is frozen here for the whole word.
            w_word_nxt     = fifo_data;
            w_div_nxt      = (baud_divisor == 16'd0) ? 16'd1 : baud_divisor;
            w_byte_idx_nxt = 1'b0;
            w_baud_cnt_nxt = 16'd0;
            w_bit_cnt_nxt  = 3'd0;
            w_state_nxt    = S_START;
         end
         S_START: begin
            if (w_bit_end) begin
               w_baud_cnt_nxt = 16'd0;
               w_state_nxt    = S_DATA;
            end else begin
               w_baud_cnt_nxt = r_baud_cnt + 16'd1;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_baud_cnt_nxt = 16'd0;
               if (r_bit_cnt == c_last_data) begin
                  w_bit_cnt_nxt = 3'd0;
                  w_state_nxt   = PARITY_EN ? S_PARITY : S_STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end else begin
               w_baud_cnt_nxt = r_baud_cnt + 16'd1;
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_baud_cnt_nxt = 16'd0;
               w_state_nxt    = S_STOP;
            end else begin
               w_baud_cnt_nxt = r_baud_cnt + 16'd1;
            end
         end
         S_STOP: begin
            // The bit counter doubles as the stop-bit counter.
            if (w_bit_end) begin
               w_baud_cnt_nxt = 16'd0;
               if (r_bit_cnt == c_last_stop) begin
                  w_bit_cnt_nxt = 3'd0;
                  if (!r_byte_idx) begin
                     w_byte_idx_nxt = 1'b1;
                     w_state_nxt    = S_START;
                  end else begin
                     w_word_done_nxt = 1'b1;
                     w_state_nxt     = S_IDLE;
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end else begin
               w_baud_cnt_nxt = r_baud_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // tx is registered, so it is derived from where the FSM is heading.
      w_byte_nxt = ((w_byte_idx_nxt == 1'b0) == LSB_FIRST_BYTE) ? w_word_nxt[7:0]
                                                                 : w_word_nxt[15:8];
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_byte_nxt[w_bit_cnt_nxt];
         S_PARITY: w_tx_nxt = (^w_byte_nxt) ^ PARITY_ODD;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_word      <= 16'd0;
         r_div       <= 16'd0;
         r_baud_cnt  <= 16'd0;
         r_bit_cnt   <= 3'd0;
         r_byte_idx  <= 1'b0;
         r_word_done <= 1'b0;
         r_tx        <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_word      <= w_word_nxt;
         r_div       <= w_div_nxt;
         r_baud_cnt  <= w_baud_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_byte_idx  <= w_byte_idx_nxt;
         r_word_done <= w_word_done_nxt;
         r_tx        <= w_tx_nxt;
      end
   end

   assign rd_en     = (r_state == S_REQ);
   assign busy      = (r_state != S_IDLE);
   assign word_done = r_word_done;
   assign tx        = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_tx
//  Description : Bench for uart_word_tx; three parameter variants share one
//                FIFO model and a per-cycle waveform reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

   localparam int K_NORM  = 0;
   localparam int K_LATCH = 1;
   localparam int K_IDLE  = 2;

   typedef struct {
      logic tx;
      logic rd;
      logic busy;
      logic done;
      int   kind;
   } ent_t;

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] word;
      logic [15:0] div;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        p0;
      logic        p1;
      int          clocks;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] baud_divisor;
   logic [15:0] fifo_data;
   logic        fifo_empty;
   logic [1:0]  sel;
   logic [2:0]  en_v, tx_v, rd_v, busy_v, done_v, selmask;

   int          n_vec = 0;
   int          n_mis = 0;
   int          n_rd, n_done;
   logic [15:0] m_word;
   logic [15:0] fifo_q[$];
   ent_t        eq[$];
   logic        trace[$];
   int          done_at[$];

   always #5 clk = ~clk;

   assign selmask = 3'b001 << sel;
   assign en_v    = enable ? selmask : 3'b000;

   uart_word_tx #(.LSB_FIRST_BYTE(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .enable(en_v[0]), .baud_divisor(baud_divisor),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .rd_en(rd_v[0]),
      .tx(tx_v[0]), .busy(busy_v[0]), .word_done(done_v[0]));

   uart_word_tx #(.LSB_FIRST_BYTE(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .rst(rst), .enable(en_v[1]), .baud_divisor(baud_divisor),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .rd_en(rd_v[1]),
      .tx(tx_v[1]), .busy(busy_v[1]), .word_done(done_v[1]));

   uart_word_tx #(.LSB_FIRST_BYTE(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .rst(rst), .enable(en_v[2]), .baud_divisor(baud_divisor),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .rd_en(rd_v[2]),
      .tx(tx_v[2]), .busy(busy_v[2]), .word_done(done_v[2]));

   function automatic logic m_lsb(input logic [1:0] s);
      return (s != 2'd2);
   endfunction
   function automatic logic m_par(input logic [1:0] s);
      return (s != 2'd0);
   endfunction
   function automatic logic m_odd(input logic [1:0] s);
      return (s == 2'd2);
   endfunction
   function automatic int m_stop(input logic [1:0] s);
      return (s == 2'd1) ? 2 : 1;
   endfunction
   function automatic int eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 1 : int'(d);
   endfunction
   function automatic logic tr(input int idx);
      if (idx >= 0 && idx < trace.size()) return trace[idx];
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic push_bits(input logic b, input int n);
      for (int i = 0; i < n; i++) eq.push_back('{b, 1'b0, 1'b1, 1'b0, K_NORM});
   endtask

   // Expected tx stream of one word: each UART bit held for d clocks.
   task automatic build_frame(input logic [15:0] w, input int d);
      logic [7:0] b;
      for (int j = 0; j < 2; j++) begin
         b = (m_lsb(sel) == (j == 0)) ? w[7:0] : w[15:8];
         push_bits(1'b0, d);
         for (int i = 0; i < 8; i++) push_bits(b[i], d);
         if (m_par(sel)) push_bits((^b) ^ m_odd(sel), d);
         push_bits(1'b1, d * m_stop(sel));
      end
      eq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, K_IDLE});
   endtask

   // Compare this cycle's outputs, advance the model, then step to the next negedge.
   task automatic tick();
      ent_t e;
      logic pop_now;
      if (eq.size() == 0) e = '{1'b1, 1'b0, 1'b0, 1'b0, K_IDLE};
      else                e = eq.pop_front();
      check("cycle", 32'({tx_v[sel], rd_v[sel], busy_v[sel], done_v[sel]}),
                     32'({e.tx, e.rd, e.busy, e.done}));
      check("others_idle", 32'({tx_v | selmask, rd_v & ~selmask, busy_v & ~selmask, done_v & ~selmask}),
                           32'({3'b111, 3'b000, 3'b000, 3'b000}));
      trace.push_back(tx_v[sel]);
      if (rd_v[sel]) n_rd++;
      if (done_v[sel]) begin
         n_done++;
         done_at.push_back(trace.size() - 1);
      end
      if (e.kind == K_LATCH) begin
         build_frame(m_word, eff_div(baud_divisor));
      end else if (e.kind == K_IDLE && !rst && enable && fifo_q.size() != 0) begin
         m_word = fifo_q[0];
         eq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, K_NORM});
         eq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, K_LATCH});
      end
      pop_now = |rd_v;
      @(posedge clk);
      #1;
      if (pop_now) begin
         check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
      @(negedge clk);
   endtask

   task automatic drain(input string name, input int budget);
      int cnt = 0;
      while ((fifo_q.size() != 0 || eq.size() != 0) && cnt < budget) begin
         tick();
         cnt++;
      end
      check(name, 32'(cnt < budget), 32'd1);
   endtask

   function automatic int first_fall();
      for (int i = 0; i < trace.size(); i++) if (trace[i] == 1'b0) return i;
      return -1000;
   endfunction

   // Send one word and decode the captured waveform like a UART receiver.
   task automatic run_vec(input vec_t v);
      int cnt, t0, td, d, blen;
      logic [7:0] got [2];
      logic       gp [2];
      sel = v.sel;
      baud_divisor = v.div;
      push_word(v.word);
      enable = 1'b1;
      trace.delete();
      done_at.delete();
      n_done = 0;
      cnt = 0;
      while (n_done == 0 && cnt < 2000) begin
         tick();
         cnt++;
      end
      enable = 1'b0;
      check("vec_done_seen", 32'(n_done), 32'd1);
      t0   = first_fall();
      td   = trace.size() - 1;
      d    = eff_div(v.div);
      blen = (9 + (m_par(v.sel) ? 1 : 0) + m_stop(v.sel)) * d;
      check("vec_clocks", 32'(td - t0), 32'(v.clocks));
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < 8; i++) got[j][i] = tr(t0 + j * blen + d * (1 + i) + d / 2);
         gp[j] = tr(t0 + j * blen + d * 9 + d / 2);
      end
      check("vec_byte0", 32'(got[0]), 32'(v.b0));
      check("vec_byte1", 32'(got[1]), 32'(v.b1));
      if (m_par(v.sel)) begin
         check("vec_par0", 32'(gp[0]), 32'(v.p0));
         check("vec_par1", 32'(gp[1]), 32'(v.p1));
      end
      tick();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int   cnt, t0;
      vt[0] = '{2'd0, 16'hA55A, 16'd4, 8'h5A, 8'hA5, 1'b0, 1'b0, 80};
      vt[1] = '{2'd0, 16'h00FF, 16'd0, 8'hFF, 8'h00, 1'b0, 1'b0, 20};
      vt[2] = '{2'd1, 16'h0107, 16'd3, 8'h07, 8'h01, 1'b1, 1'b1, 72};
      vt[3] = '{2'd2, 16'h1234, 16'd2, 8'h12, 8'h34, 1'b1, 1'b0, 44};
      vt[4] = '{2'd0, 16'hFFFF, 16'd1, 8'hFF, 8'hFF, 1'b0, 1'b0, 20};
      vt[5] = '{2'd1, 16'h80C3, 16'd1, 8'hC3, 8'h80, 1'b0, 1'b1, 24};

      rst = 1'b1; enable = 1'b0; baud_divisor = 16'd4;
      fifo_data = 16'd0; fifo_empty = 1'b1; sel = 2'd0;
      n_rd = 0; n_done = 0; m_word = 16'd0;
      @(negedge clk);
      check("reset_state", 32'({tx_v, rd_v, busy_v, done_v}), 32'({3'b111, 9'b0}));
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 6; k++) run_vec(vt[k]);

      // Three queued words, back to back.
      sel = 2'd0; baud_divisor = 16'd2;
      trace.delete(); done_at.delete(); n_rd = 0; n_done = 0;
      for (int k = 0; k < 3; k++) push_word(16'h1111 * 16'(k + 1));
      enable = 1'b1;
      drain("b2b_drain", 1000);
      enable = 1'b0;
      check("b2b_rd_count", 32'(n_rd), 32'd3);
      check("b2b_done_count", 32'(n_done), 32'd3);
      for (int k = 0; k < 2 && k < done_at.size(); k++)
         check("b2b_gap", 32'({tr(done_at[k]), tr(done_at[k] + 1), tr(done_at[k] + 2), tr(done_at[k] + 3)}),
                          32'(4'b1110));

      // Reset in the middle of byte 0 data bits.
      sel = 2'd0; baud_divisor = 16'd4; trace.delete();
      push_word(16'h1357);
      enable = 1'b1;
      cnt = 0;
      while (first_fall() < 0 && cnt < 200) begin tick(); cnt++; end
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1; enable = 1'b0;
      #1;
      check("rst_tx", 32'(tx_v[0]), 32'd1);
      check("rst_busy", 32'(busy_v[0]), 32'd0);
      eq.delete();
      tick(); tick();
      rst = 1'b0;
      tick();
      run_vec('{2'd0, 16'hC3A5, 16'd3, 8'hA5, 8'hC3, 1'b0, 1'b0, 60});

      // Divisor change and enable drop mid-word.
      sel = 2'd0; baud_divisor = 16'd4;
      trace.delete(); done_at.delete(); n_rd = 0; n_done = 0;
      push_word(16'h6C39); push_word(16'h9AB0);
      enable = 1'b1;
      cnt = 0;
      while (first_fall() < 0 && cnt < 200) begin tick(); cnt++; end
      for (int i = 0; i < 20; i++) tick();
      baud_divisor = 16'd8; enable = 1'b0;
      cnt = 0;
      while (n_done == 0 && cnt < 500) begin tick(); cnt++; end
      for (int i = 0; i < 40; i++) tick();
      t0 = first_fall();
      check("mid_done_at", 32'((done_at.size() > 0) ? done_at[0] - t0 : -1), 32'd80);
      check("mid_rd_count", 32'(n_rd), 32'd1);
      check("mid_word_left", 32'(fifo_q.size()), 32'd1);
      enable = 1'b1;
      drain("mid_drain", 1000);
      enable = 1'b0;

      // Randomized traffic across all three variants.
      for (int r = 0; r < 12; r++) begin
         sel = 2'(r % 3);
         baud_divisor = 16'($urandom_range(0, 5));
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) push_word(16'($urandom));
         cnt = 0;
         while ((fifo_q.size() != 0 || eq.size() != 0) && cnt < 3000) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) baud_divisor = 16'($urandom_range(0, 5));
            tick();
            cnt++;
         end
         check("rand_drain", 32'(cnt < 3000), 32'd1);
         enable = 1'b0;
         tick(); tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
